mem_io_responder: RTL and testbench

Byte-wide responder for the CPU memory bus: the target the memory controller drives through `mem_a`/`mem_wr`/`mem_dout` and samples through `mem_din`. It holds a synchronous byte RAM and a memory-mapped I/O window with a TX FIFO toward the UART side and an RX FIFO from it. It also generates the `io_buffer_full` back-pressure flag that the controller checks before issuing an I/O store. It sits between the controller and the external RAM/UART models at the top level.

---
 rtl/mem_io_responder_if.sv | 30 +++
 rtl/mem_io_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_io_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Bus and UART-side signal bundle for mem_io_responder.
// master = memory controller / UART models, slave = the responder.
interface mem_io_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        tx_overflow;
  logic        sim_halt;

  modport master (
    output rdy, mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
    input  mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready,
           tx_overflow, sim_halt
  );

  modport slave (
    input  rdy, mem_a, mem_wr, mem_wdata, tx_ready, rx_data, rx_valid,
    output mem_rdata, io_buffer_full, tx_data, tx_valid, rx_ready,
           tx_overflow, sim_halt
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped TX/RX FIFO window behind the CPU memory bus.
// Reads have one cycle of latency; the UART side of both FIFOs ignores rdy.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  mem_io_responder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(FIFO_DEPTH - 2);

  // ---------------- address decode ----------------
  logic                  is_io;
  logic [2:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  unused_addr;

  assign is_io       = (bus.mem_a[17:16] == 2'b11);
  assign io_off      = bus.mem_a[2:0];
  assign ram_idx     = bus.mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^bus.mem_a[31:18];

  // ---------------- RAM (read-first, not reset) ----------------
  logic [7:0] ram [(1<<ADDR_WIDTH)];
  logic [7:0] ram_q_reg;
  logic       ram_en;
  logic       ram_we;

  assign ram_en = bus.rdy && !is_io;
  assign ram_we = ram_en && bus.mem_wr;

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_idx] <= bus.mem_wdata;
    if (ram_en)
      ram_q_reg <= ram[ram_idx];
  end

  // ---------------- FIFO state ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [PW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0] tx_count_reg, rx_count_reg;
  logic [CW-1:0] tx_count_next, rx_count_next;

  logic tx_full, tx_nonempty, rx_nonempty, rx_not_full;
  logic io_rd0, io_wr0, io_wr4;
  logic tx_push_req, tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop;

  assign tx_full     = (tx_count_reg == DEPTH_C);
  assign tx_nonempty = (tx_count_reg != '0);
  assign rx_nonempty = (rx_count_reg != '0);
  assign rx_not_full = (rx_count_reg != DEPTH_C);

  assign io_rd0 = bus.rdy && is_io && !bus.mem_wr && (io_off == 3'd0);
  assign io_wr0 = bus.rdy && is_io &&  bus.mem_wr && (io_off == 3'd0);
  assign io_wr4 = bus.rdy && is_io &&  bus.mem_wr && (io_off == 3'd4);

  // A push into a full TX FIFO is accepted when the head leaves the same cycle.
  assign tx_push_req = io_wr0;
  assign tx_pop      = tx_nonempty && bus.tx_ready;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop     = tx_push_req && tx_full && !tx_pop;

  assign rx_push = bus.rx_valid && rx_not_full;
  assign rx_pop  = io_rd0 && rx_nonempty;

  always_comb begin
    tx_count_next = tx_count_reg;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count_reg + CW'(1);
      2'b01:   tx_count_next = tx_count_reg - CW'(1);
      default: tx_count_next = tx_count_reg;
    endcase
  end

  always_comb begin
    rx_count_next = rx_count_reg;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count_reg + CW'(1);
      2'b01:   rx_count_next = rx_count_reg - CW'(1);
      default: rx_count_next = rx_count_reg;
    endcase
  end

  // FIFO storage arrays carry no reset; validity comes from the counts.
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr_ptr_reg] <= bus.mem_wdata;
    if (rx_push)
      rx_mem[rx_wr_ptr_reg] <= bus.rx_data;
  end

  // ---------------- I/O read data ----------------
  logic [7:0] io_rdata_next;

  always_comb begin
    io_rdata_next = 8'h00;
    if (!bus.mem_wr) begin
      case (io_off)
        3'd0:    io_rdata_next = rx_nonempty ? rx_mem[rx_rd_ptr_reg] : 8'h00;
        3'd4:    io_rdata_next = {6'b0, tx_full, rx_nonempty};
        default: io_rdata_next = 8'h00;
      endcase
    end
  end

  // ---------------- control registers ----------------
  logic [7:0] io_rdata_reg;
  logic       sel_ram_reg;
  logic       io_buffer_full_reg;
  logic       tx_overflow_reg;
  logic       sim_halt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg      <= '0;
      tx_rd_ptr_reg      <= '0;
      rx_wr_ptr_reg      <= '0;
      rx_rd_ptr_reg      <= '0;
      tx_count_reg       <= '0;
      rx_count_reg       <= '0;
      io_rdata_reg       <= 8'h00;
      sel_ram_reg        <= 1'b0;
      io_buffer_full_reg <= 1'b0;
      tx_overflow_reg    <= 1'b0;
      sim_halt_reg       <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
      tx_count_reg <= tx_count_next;
      rx_count_reg <= rx_count_next;

      // Two slots of margin: one store already in flight plus this register's lag.
      io_buffer_full_reg <= (tx_count_next >= NEAR_FULL_C);

      if (tx_drop) tx_overflow_reg <= 1'b1;
      if (io_wr4)  sim_halt_reg    <= 1'b1;

      if (bus.rdy) begin
        sel_ram_reg <= !is_io;
        if (is_io)
          io_rdata_reg <= io_rdata_next;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.mem_rdata      = sel_ram_reg ? ram_q_reg : io_rdata_reg;
  assign bus.io_buffer_full = io_buffer_full_reg;
  assign bus.tx_valid       = tx_nonempty;
  assign bus.tx_data        = tx_nonempty ? tx_mem[tx_rd_ptr_reg] : 8'h00;
  assign bus.rx_ready       = rx_not_full;
  assign bus.tx_overflow    = tx_overflow_reg;
  assign bus.sim_halt       = sim_halt_reg;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a RAM/I-O vector table followed by
// hand-written FIFO, rdy, reset and halt sequences.
module tb_mem_io_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_io_responder_if io ();

  mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        rdy;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wd;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [15];
  logic [7:0] q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("check %s: got %0h ok", nm, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction: present for one edge, then return to an idle RAM read.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [7:0] d);
    io.mem_a     = a;
    io.mem_wr    = w;
    io.mem_wdata = d;
    cyc();
    io.mem_wr    = 1'b0;
    io.mem_a     = 32'h0;
    io.mem_wdata = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    io.rdy = 1'b1; io.mem_a = 32'h0; io.mem_wr = 1'b0; io.mem_wdata = 8'h00;
    io.tx_ready = 1'b0; io.rx_data = 8'h00; io.rx_valid = 1'b0;

    //             rdy  addr          wr    wd     chk   exp
    tbl[0]  = '{1'b1, 32'h0000_0100, 1'b1, 8'h11, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 32'h0000_0101, 1'b1, 8'h22, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 32'h0000_0102, 1'b1, 8'h33, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 32'h0000_0103, 1'b1, 8'h44, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 32'h0000_0101, 1'b0, 8'h00, 1'b1, 8'h22};
    tbl[6]  = '{1'b1, 32'h0000_0102, 1'b0, 8'h00, 1'b1, 8'h33};
    tbl[7]  = '{1'b1, 32'h0000_0103, 1'b0, 8'h00, 1'b1, 8'h44};
    tbl[8]  = '{1'b1, 32'h0002_0101, 1'b0, 8'h00, 1'b1, 8'h22};
    tbl[9]  = '{1'b1, 32'h0003_0002, 1'b1, 8'h99, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 32'h0003_0002, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[11] = '{1'b1, 32'h0000_0103, 1'b0, 8'h00, 1'b1, 8'h44};
    tbl[12] = '{1'b0, 32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'h44};
    tbl[13] = '{1'b0, 32'h0000_0101, 1'b1, 8'hEE, 1'b0, 8'h00};
    tbl[14] = '{1'b1, 32'h0000_0101, 1'b0, 8'h00, 1'b1, 8'h22};

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_mem_rdata", io.mem_rdata, 8'h00);
    chk("rst_io_buffer_full", io.io_buffer_full, 1'b0);
    chk("rst_tx_valid", io.tx_valid, 1'b0);
    chk("rst_tx_data", io.tx_data, 8'h00);
    chk("rst_rx_ready", io.rx_ready, 1'b1);
    chk("rst_tx_overflow", io.tx_overflow, 1'b0);
    chk("rst_sim_halt", io.sim_halt, 1'b0);

    // RAM / decode vectors, back to back
    for (int i = 0; i < 15; i++) begin
      io.rdy       = tbl[i].rdy;
      io.mem_a     = tbl[i].a;
      io.mem_wr    = tbl[i].wr;
      io.mem_wdata = tbl[i].wd;
      cyc();
      if (tbl[i].chk)
        chk($sformatf("vec%0d_rdata", i), io.mem_rdata, tbl[i].exp);
    end
    io.rdy = 1'b1; io.mem_wr = 1'b0; io.mem_a = 32'h0;

    // TX fill with no consumer: near-full flag after 6th push, 9th byte dropped
    io.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      xfer(32'h0003_0000, 1'b1, 8'hA0 + 8'(i));
      chk($sformatf("fill%0d_io_buffer_full", i), io.io_buffer_full, (i >= 5));
    end
    chk("fill_overflow_before", io.tx_overflow, 1'b0);
    xfer(32'h0003_0000, 1'b1, 8'hA8);
    chk("fill_overflow_after", io.tx_overflow, 1'b1);

    io.tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_tx_valid", k), io.tx_valid, 1'b1);
      chk($sformatf("drain%0d_tx_data", k), io.tx_data, 8'hA0 + 8'(k));
      cyc();
    end
    chk("drain_tx_valid_low", io.tx_valid, 1'b0);
    chk("drain_io_buffer_full", io.io_buffer_full, 1'b0);
    io.tx_ready = 1'b0;

    // RX fill from UART, then bus pops
    io.rx_valid = 1'b1; io.rx_data = 8'h5A; cyc();
    io.rx_data = 8'h5B; cyc();
    io.rx_valid = 1'b0;
    xfer(32'h0003_0004, 1'b0, 8'h00); chk("rx_status1", io.mem_rdata, 8'h01);
    xfer(32'h0003_0000, 1'b0, 8'h00); chk("rx_pop0", io.mem_rdata, 8'h5A);
    xfer(32'h0003_0000, 1'b0, 8'h00); chk("rx_pop1", io.mem_rdata, 8'h5B);
    xfer(32'h0003_0000, 1'b0, 8'h00); chk("rx_pop_empty", io.mem_rdata, 8'h00);
    xfer(32'h0003_0004, 1'b0, 8'h00); chk("rx_status0", io.mem_rdata, 8'h00);

    // rdy=0 freezes the bus side
    io.rx_valid = 1'b1; io.rx_data = 8'h77; cyc();
    io.rx_valid = 1'b0;
    xfer(32'h0000_0200, 1'b1, 8'h12);
    xfer(32'h0000_0200, 1'b0, 8'h00); chk("rdy_pre_read", io.mem_rdata, 8'h12);
    io.rdy = 1'b0;
    xfer(32'h0000_0200, 1'b1, 8'hFF); chk("rdy0_wr_hold", io.mem_rdata, 8'h12);
    xfer(32'h0003_0000, 1'b0, 8'h00); chk("rdy0_pop_hold", io.mem_rdata, 8'h12);
    io.rdy = 1'b1;
    xfer(32'h0003_0004, 1'b0, 8'h00); chk("rdy1_status", io.mem_rdata, 8'h01);
    xfer(32'h0003_0000, 1'b0, 8'h00); chk("rdy1_rx_kept", io.mem_rdata, 8'h77);
    xfer(32'h0000_0200, 1'b0, 8'h00); chk("rdy1_ram_kept", io.mem_rdata, 8'h12);

    // Simultaneous push/pop keeps the TX count steady
    do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      xfer(32'h0003_0000, 1'b1, 8'hB0 + 8'(i));
      q.push_back(8'hB0 + 8'(i));
    end
    io.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream%0d_tx_data", i), io.tx_data, q[0]);
      xfer(32'h0003_0000, 1'b1, 8'hC0 + 8'(i));
      void'(q.pop_front());
      q.push_back(8'hC0 + 8'(i));
    end
    io.tx_ready = 1'b0;
    chk("stream_tx_data_end", io.tx_data, q[0]);
    chk("stream_io_buffer_full", io.io_buffer_full, 1'b0);
    chk("stream_overflow", io.tx_overflow, 1'b0);
    for (int i = 0; i < 3; i++) begin
      xfer(32'h0003_0000, 1'b1, 8'hD0 + 8'(i));
      chk($sformatf("count%0d_io_buffer_full", i + 4), io.io_buffer_full, (i == 2));
    end
    io.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io.rx_data = 8'hE0 + 8'(i);
      cyc();
    end
    io.rx_valid = 1'b0;
    chk("rx_full_ready", io.rx_ready, 1'b0);

    // Reset mid-stream
    io.tx_ready = 1'b1; io.mem_a = 32'h0003_0000; io.mem_wr = 1'b1; io.mem_wdata = 8'hF0;
    rst = 1'b1;
    cyc();
    rst = 1'b0; io.mem_wr = 1'b0; io.mem_a = 32'h0; io.tx_ready = 1'b0;
    chk("midrst_tx_valid", io.tx_valid, 1'b0);
    chk("midrst_io_buffer_full", io.io_buffer_full, 1'b0);
    chk("midrst_rx_ready", io.rx_ready, 1'b1);
    chk("midrst_tx_overflow", io.tx_overflow, 1'b0);

    // Halt register is sticky until reset
    chk("halt_before", io.sim_halt, 1'b0);
    xfer(32'h0003_0004, 1'b1, 8'h00);
    chk("halt_set", io.sim_halt, 1'b1);
    cyc(); cyc(); cyc();
    chk("halt_sticky", io.sim_halt, 1'b1);
    do_reset();
    chk("halt_cleared", io.sim_halt, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
